// File: rtl/systolic_array_ctrl_pkg.sv
// Shared definitions for the systolic array job sequencer.
// Holds the phase state encoding, the dataflow mode encodings and a small
// helper that tells whether a mode keeps an operand stationary in the PEs.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FILL   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_OS  = 2'b00;
  localparam logic [1:0] MODE_WS  = 2'b01;
  localparam logic [1:0] MODE_IS  = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  // WS and IS preload a stationary operand; OS accumulates in place instead.
  function automatic logic is_stationary(input logic [1:0] mode);
    return (mode == MODE_WS) || (mode == MODE_IS);
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Job/feeder bus of the systolic array sequencer.
//   master : job requester / testbench side (drives start, abort, mode, count)
//   slave  : sequencer side (drives status, PE control lines, feeder handshake)
interface systolic_array_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 16
) ();
  import systolic_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [1:0]       dataflow_mode;
  logic [CNT_W-1:0] num_steps;
  logic             busy;
  logic             done;
  logic             err;
  logic             array_rst_out;
  logic             stat_bit_out;
  logic [ROWS-1:0]  op2_sel_out;
  logic [ROWS-1:0]  out_sel_out;
  logic             feed_valid;
  logic             feed_sel;
  logic [CNT_W-1:0] step_idx;

  modport master (
    output start, abort, dataflow_mode, num_steps,
    input  busy, done, err, array_rst_out, stat_bit_out, op2_sel_out,
           out_sel_out, feed_valid, feed_sel, step_idx
  );

  modport slave (
    input  start, abort, dataflow_mode, num_steps,
    output busy, done, err, array_rst_out, stat_bit_out, op2_sel_out,
           out_sel_out, feed_valid, feed_sel, step_idx
  );
endinterface

// File: rtl/systolic_array_ctrl_phase_counter.sv
// Loadable down-counter used to time sequencer phases.
//   clk, rst      : clock, synchronous active-high reset
//   load_i/val_i  : load a new count (has priority over decrement)
//   dec_i         : decrement by one
//   cnt_nxt_o     : value the counter takes at the next edge (look-ahead)
//   zero_o        : current count is zero
module phase_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign zero_o    = (cnt_q == {W{1'b0}});
endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a ROWS x COLS systolic MAC array.
// Per job: CLEAR the array, FILL stationary operands (WS/IS), STREAM operand
// vectors plus the wavefront skew flush, DRAIN accumulators (OS), then DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of systolic_array_ctrl_if (job request, status,
//              PE control lines, edge-feeder handshake)
// Every output is registered from the next-state view, so the value seen in a
// cycle describes the phase the sequencer is in during that cycle.
module systolic_array_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_array_ctrl_if.slave bus
);
  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] FILL_M1 = PW'(ROWS - 1);        // FILL/DRAIN length - 1
  localparam logic [PW-1:0] SKEW_M1 = PW'(ROWS + COLS - 3); // stream tail - 1
  localparam logic [PW-1:0] SKEW    = PW'(ROWS + COLS - 2); // skew flush length
  localparam logic [PW-1:0] ONE     = PW'(1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] nsteps_q, nsteps_d;

  logic             ph_load, ph_dec, ph_zero, st_load, st_dec, st_zero;
  logic [PW-1:0]    ph_val, ph_nxt, st_val, st_nxt;
  logic [PW-1:0]    stream_len_m1, stream_idx_m1, step_base, step_full;

  logic             busy_q, done_q, err_q, arst_q, stat_q, fv_q, fsel_q;
  logic             busy_d, done_d, err_d, arst_d, stat_d, fv_d, fsel_d;
  logic [ROWS-1:0]  op2_q, op2_d, outsel_q, outsel_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  // Stream length is num_steps + ROWS + COLS - 2, kept one bit wider so
  // num_steps = all ones cannot wrap.
  assign stream_len_m1 = {1'b0, nsteps_q} + SKEW_M1;
  assign stream_idx_m1 = {1'b0, nsteps_q} - ONE;

  // Remaining cycles of the current phase.
  phase_counter #(.W(PW)) u_phase (
    .clk(clk), .rst(rst), .load_i(ph_load), .load_val_i(ph_val),
    .dec_i(ph_dec), .cnt_nxt_o(ph_nxt), .zero_o(ph_zero)
  );

  // Remaining vectors to request; step_idx is derived from it.
  phase_counter #(.W(PW)) u_step (
    .clk(clk), .rst(rst), .load_i(st_load), .load_val_i(st_val),
    .dec_i(st_dec), .cnt_nxt_o(st_nxt), .zero_o(st_zero)
  );

  // Phase sequencing, job latch and counter control.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    nsteps_d = nsteps_q;
    err_d    = 1'b0;
    ph_load  = 1'b0;
    ph_val   = {PW{1'b0}};
    ph_dec   = 1'b0;
    st_load  = 1'b0;
    st_val   = {PW{1'b0}};
    st_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && ((bus.dataflow_mode == MODE_ILL) ||
                          (bus.num_steps == {CNT_W{1'b0}}))) begin
          err_d = 1'b1;
        end else if (bus.start) begin
          mode_d   = bus.dataflow_mode;
          nsteps_d = bus.num_steps;
          state_d  = CLEAR;
          ph_load  = 1'b1;  // CLEAR lasts one cycle
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (is_stationary(mode_q)) begin
          state_d = FILL;
          ph_load = 1'b1;  ph_val = FILL_M1;
          st_load = 1'b1;  st_val = FILL_M1;
        end else begin
          state_d = STREAM;
          ph_load = 1'b1;  ph_val = stream_len_m1;
          st_load = 1'b1;  st_val = stream_idx_m1;
        end
      end
      FILL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          state_d = STREAM;
          ph_load = 1'b1;  ph_val = stream_len_m1;
          st_load = 1'b1;  st_val = stream_idx_m1;
        end else begin
          ph_dec = 1'b1;
          st_dec = ~st_zero;
        end
      end
      STREAM: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (ph_zero && is_stationary(mode_q)) begin
          state_d = DONE;
        end else if (ph_zero) begin
          state_d = DRAIN;
          ph_load = 1'b1;  ph_val = FILL_M1;
        end else begin
          ph_dec = 1'b1;
          st_dec = ~st_zero;  // step_idx holds at the last vector during flush
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          state_d = DONE;
        end else begin
          ph_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    arst_d    = (state_d == CLEAR);
    stat_d    = (state_d != IDLE) && is_stationary(mode_d);
    outsel_d  = (state_d == DRAIN) ? {ROWS{1'b1}} : {ROWS{1'b0}};
    op2_d     = {ROWS{1'b0}};
    fv_d      = 1'b0;
    fsel_d    = 1'b0;
    step_base = {PW{1'b0}};
    step_full = {PW{1'b0}};
    idx_d     = {CNT_W{1'b0}};
    case (state_d)
      FILL: begin
        fv_d      = 1'b1;
        op2_d     = (ph_nxt == {PW{1'b0}}) ? {ROWS{1'b1}} : {ROWS{1'b0}};
        step_base = FILL_M1;
        step_full = step_base - st_nxt;
        idx_d     = step_full[CNT_W-1:0];
      end
      STREAM: begin
        fsel_d    = 1'b1;
        fv_d      = (ph_nxt >= SKEW);  // first num_steps cycles of the phase
        step_base = stream_idx_m1;
        step_full = step_base - st_nxt;
        idx_d     = step_full[CNT_W-1:0];
      end
      default: begin
        idx_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, job latch and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_OS;
      nsteps_q <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      arst_q   <= 1'b0;
      stat_q   <= 1'b0;
      op2_q    <= {ROWS{1'b0}};
      outsel_q <= {ROWS{1'b0}};
      fv_q     <= 1'b0;
      fsel_q   <= 1'b0;
      idx_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      nsteps_q <= nsteps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      arst_q   <= arst_d;
      stat_q   <= stat_d;
      op2_q    <= op2_d;
      outsel_q <= outsel_d;
      fv_q     <= fv_d;
      fsel_q   <= fsel_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.array_rst_out = arst_q;
  assign bus.stat_bit_out  = stat_q;
  assign bus.op2_sel_out   = op2_q;
  assign bus.out_sel_out   = outsel_q;
  assign bus.feed_valid    = fv_q;
  assign bus.feed_sel      = fsel_q;
  assign bus.step_idx      = idx_q;
endmodule
